// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: operand select codes and
// the bubble FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUBBLE  = 2'd1,
    ST_MEMWAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/fwd_match.sv
// Forwarding select for one source operand against a newer and an older
// producer; the newer producer wins, x0 is never forwarded.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] new_rd,
  input  logic              new_we,
  input  logic [REG_AW-1:0] old_rd,
  input  logic              old_we,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (new_we && (new_rd != '0) && (new_rd == rs)) begin
      sel = FWD_MEM;
    end else if (old_we && (old_rd != '0) && (old_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding selects, load-use / branch-dependency bubble FSM, memory-wait
// freeze and saturating hazard counters for the 5-stage core.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_branch,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_regwrite,
  input  logic                      mem_memread,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_regwrite,
  input  logic                      dmem_stall,
  input  logic                      cnt_clr,
  output logic [NUM_SRC*2-1:0]      ex_fwd_sel,
  output logic [NUM_SRC*2-1:0]      id_fwd_sel,
  output logic                      stall_pc,
  output logic                      stall_ifid,
  output logic                      bubble_idex,
  output logic                      freeze_all,
  output logic [CNT_W-1:0]          cnt_stall,
  output logic [CNT_W-1:0]          cnt_loaduse,
  output logic [1:0]                dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]         src_need [NUM_SRC];
  logic [NUM_SRC-1:0] src_load;
  logic [1:0]         need;
  logic               load_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] rs_id;
    logic              ex_hit;
    logic              mem_hit;

    assign rs_id   = id_rs[i*REG_AW +: REG_AW];
    assign ex_hit  = ex_regwrite  && (ex_rd  != '0) && (ex_rd  == rs_id);
    assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == rs_id);

    // A load still in EX needs two slots before a branch in ID can compare.
    assign src_need[i] = !id_rs_used[i]                       ? 2'd0 :
                         (ex_hit && ex_memread && id_branch)  ? 2'd2 :
                         (ex_hit && (ex_memread || id_branch)) ? 2'd1 :
                         (mem_hit && mem_memread && id_branch) ? 2'd1 : 2'd0;
    assign src_load[i] = id_rs_used[i] &&
                         ((ex_hit && ex_memread) || (mem_hit && mem_memread && id_branch));

    fwd_match #(.REG_AW(REG_AW)) u_ex_fwd (
      .rs     (ex_rs[i*REG_AW +: REG_AW]),
      .new_rd (mem_rd),
      .new_we (mem_regwrite),
      .old_rd (wb_rd),
      .old_we (wb_regwrite),
      .sel    (ex_fwd_sel[i*2 +: 2])
    );

    fwd_match #(.REG_AW(REG_AW)) u_id_fwd (
      .rs     (rs_id),
      .new_rd (mem_rd),
      .new_we (mem_regwrite),
      .old_rd (wb_rd),
      .old_we (wb_regwrite),
      .sel    (id_fwd_sel[i*2 +: 2])
    );
  end

  always_comb begin
    need = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_need[i] > need) need = src_need[i];
    end
  end

  assign load_hit = |src_load;

  hz_state_e        state_q, state_d, eff_state;
  logic [1:0]       bub_left_q, bub_left_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_loaduse_q, cnt_loaduse_d;
  logic             bubble;
  logic             lu_entry;

  // Leaving MEMWAIT acts as the resumed state in the same cycle, so no dead
  // cycle appears between the freeze and the remaining bubbles.
  always_comb begin
    state_d    = state_q;
    bub_left_d = bub_left_q;
    bubble     = 1'b0;
    lu_entry   = 1'b0;
    eff_state  = state_q;
    if (state_q == ST_MEMWAIT) begin
      eff_state = (bub_left_q == 2'd0) ? ST_IDLE : ST_BUBBLE;
    end
    if (dmem_stall) begin
      state_d = ST_MEMWAIT;
    end else begin
      case (eff_state)
        ST_BUBBLE: begin
          bubble     = 1'b1;
          bub_left_d = bub_left_q - 2'd1;
          state_d    = (bub_left_q <= 2'd1) ? ST_IDLE : ST_BUBBLE;
        end
        default: begin
          state_d = ST_IDLE;
          if (need != 2'd0) begin
            bubble     = 1'b1;
            lu_entry   = load_hit;
            bub_left_d = need - 2'd1;
            state_d    = (need > 2'd1) ? ST_BUBBLE : ST_IDLE;
          end
        end
      endcase
    end
  end

  assign freeze_all  = rst_n & dmem_stall;
  assign bubble_idex = rst_n & bubble;
  assign stall_pc    = bubble_idex | freeze_all;
  assign stall_ifid  = stall_pc;

  always_comb begin
    cnt_stall_d   = cnt_stall_q;
    cnt_loaduse_d = cnt_loaduse_q;
    if (cnt_clr) begin
      cnt_stall_d   = '0;
      cnt_loaduse_d = '0;
    end else begin
      if (stall_pc && (cnt_stall_q != CNT_MAX)) cnt_stall_d = cnt_stall_q + CNT_W'(1);
      if (lu_entry && (cnt_loaduse_q != CNT_MAX)) cnt_loaduse_d = cnt_loaduse_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bub_left_q    <= 2'd0;
      cnt_stall_q   <= '0;
      cnt_loaduse_q <= '0;
    end else begin
      state_q       <= state_d;
      bub_left_q    <= bub_left_d;
      cnt_stall_q   <= cnt_stall_d;
      cnt_loaduse_q <= cnt_loaduse_d;
    end
  end

  assign cnt_stall   = cnt_stall_q;
  assign cnt_loaduse = cnt_loaduse_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a per-cycle reference model of the
// forwarding/bubble/counter rules plus hand-computed scenario checks.
module tb_hazard_fwd_unit;

  localparam int NS = 2;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NS*AW-1:0] id_rs, ex_rs;
  logic [NS-1:0]    id_rs_used;
  logic             id_branch;
  logic [AW-1:0]    ex_rd, mem_rd, wb_rd;
  logic             ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic             dmem_stall, cnt_clr;
  logic [NS*2-1:0]  ex_fwd_sel, id_fwd_sel;
  logic             stall_pc, stall_ifid, bubble_idex, freeze_all;
  logic [CW-1:0]    cnt_stall, cnt_loaduse;
  logic [1:0]       dbg_state;

  logic [3*AW-1:0]  s3_id_rs, s3_ex_rs;
  logic [2:0]       s3_id_rs_used;
  logic             s3_id_branch;
  logic [AW-1:0]    s3_ex_rd, s3_mem_rd, s3_wb_rd;
  logic             s3_ex_regwrite, s3_ex_memread, s3_mem_regwrite, s3_mem_memread, s3_wb_regwrite;
  logic             s3_dmem_stall, s3_cnt_clr;
  logic [5:0]       s3_ex_fwd_sel, s3_id_fwd_sel;
  logic             s3_stall_pc, s3_stall_ifid, s3_bubble_idex, s3_freeze_all;
  logic [1:0]       s3_cnt_stall, s3_cnt_loaduse;
  logic [1:0]       s3_dbg_state;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.NUM_SRC(NS), .REG_AW(AW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_branch(id_branch),
    .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_stall(dmem_stall), .cnt_clr(cnt_clr),
    .ex_fwd_sel(ex_fwd_sel), .id_fwd_sel(id_fwd_sel), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .bubble_idex(bubble_idex), .freeze_all(freeze_all),
    .cnt_stall(cnt_stall), .cnt_loaduse(cnt_loaduse), .dbg_state(dbg_state)
  );

  hazard_fwd_unit #(.NUM_SRC(3), .REG_AW(AW), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_rs(s3_id_rs), .id_rs_used(s3_id_rs_used),
    .id_branch(s3_id_branch), .ex_rs(s3_ex_rs), .ex_rd(s3_ex_rd),
    .ex_regwrite(s3_ex_regwrite), .ex_memread(s3_ex_memread), .mem_rd(s3_mem_rd),
    .mem_regwrite(s3_mem_regwrite), .mem_memread(s3_mem_memread), .wb_rd(s3_wb_rd),
    .wb_regwrite(s3_wb_regwrite), .dmem_stall(s3_dmem_stall), .cnt_clr(s3_cnt_clr),
    .ex_fwd_sel(s3_ex_fwd_sel), .id_fwd_sel(s3_id_fwd_sel), .stall_pc(s3_stall_pc),
    .stall_ifid(s3_stall_ifid), .bubble_idex(s3_bubble_idex), .freeze_all(s3_freeze_all),
    .cnt_stall(s3_cnt_stall), .cnt_loaduse(s3_cnt_loaduse), .dbg_state(s3_dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_pend = 0;
  longint m_cs = 0;
  longint m_lu = 0;

  function automatic logic [1:0] fsel(input logic [AW-1:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int need_of(output bit by_load);
    int n;
    n = 0;
    by_load = 1'b0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] rs;
      bit ex_m, mem_m;
      int k;
      rs    = id_rs[i*AW +: AW];
      ex_m  = ex_regwrite && ex_rd != 0 && ex_rd == rs;
      mem_m = mem_regwrite && mem_rd != 0 && mem_rd == rs;
      k = 0;
      if (id_rs_used[i]) begin
        if (ex_m && ex_memread) begin
          k = id_branch ? 2 : 1;
          by_load = 1'b1;
        end else if (ex_m && id_branch) begin
          k = 1;
        end
        if (mem_m && mem_memread && id_branch) begin
          if (k < 1) k = 1;
          by_load = 1'b1;
        end
      end
      if (k > n) n = k;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    bit ld, eb, ef;
    int nd;
    logic [NS*2-1:0] eex, eid;
    for (int i = 0; i < NS; i++) begin
      eex[i*2 +: 2] = fsel(ex_rs[i*AW +: AW]);
      eid[i*2 +: 2] = fsel(id_rs[i*AW +: AW]);
    end
    chk("ex_fwd_sel", 32'(ex_fwd_sel), 32'(eex));
    chk("id_fwd_sel", 32'(id_fwd_sel), 32'(eid));
    eb = 1'b0; ef = 1'b0; nd = 0; ld = 1'b0;
    if (!rst_n) begin
      m_pend = 0; m_cs = 0; m_lu = 0;
    end else if (dmem_stall) begin
      ef = 1'b1;
    end else if (m_pend > 0) begin
      eb = 1'b1;
    end else begin
      nd = need_of(ld);
      eb = (nd > 0);
    end
    chk("bubble_idex", 32'(bubble_idex), 32'(eb));
    chk("freeze_all", 32'(freeze_all), 32'(ef));
    chk("stall_pc", 32'(stall_pc), 32'(eb | ef));
    chk("stall_ifid", 32'(stall_ifid), 32'(eb | ef));
    chk("cnt_stall", 32'(cnt_stall), 32'(m_cs));
    chk("cnt_loaduse", 32'(cnt_loaduse), 32'(m_lu));
    if (rst_n) begin
      if (!dmem_stall) begin
        if (m_pend > 0) m_pend--;
        else if (nd > 0) begin
          m_pend = nd - 1;
          if (ld && m_lu < CMAX) m_lu++;
        end
      end
      if ((eb | ef) && m_cs < CMAX) m_cs++;
      if (cnt_clr) begin m_cs = 0; m_lu = 0; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; ex_rs = '0; id_rs_used = '0; id_branch = 1'b0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0; mem_memread = 1'b0;
    wb_regwrite = 1'b0; dmem_stall = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic s3_idle();
    s3_id_rs = '0; s3_ex_rs = '0; s3_id_rs_used = '0; s3_id_branch = 1'b0;
    s3_ex_rd = '0; s3_mem_rd = '0; s3_wb_rd = '0;
    s3_ex_regwrite = 1'b0; s3_ex_memread = 1'b0; s3_mem_regwrite = 1'b0;
    s3_mem_memread = 1'b0; s3_wb_regwrite = 1'b0; s3_dmem_stall = 1'b0; s3_cnt_clr = 1'b0;
  endtask

  task automatic clr();
    cyc(); idle(); cnt_clr = 1'b1;
    cyc(); cnt_clr = 1'b0;
  endtask

  // branch in ID reading r: load in EX / load in MEM / load in WB
  task automatic set_a(input logic [AW-1:0] r);
    idle(); ex_rd = r; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_branch = 1'b1; id_rs[AW-1:0] = r; id_rs_used = 2'b01;
  endtask

  task automatic set_b(input logic [AW-1:0] r);
    idle(); mem_rd = r; mem_regwrite = 1'b1; mem_memread = 1'b1;
    id_branch = 1'b1; id_rs[AW-1:0] = r; id_rs_used = 2'b01;
  endtask

  task automatic set_c(input logic [AW-1:0] r);
    idle(); wb_rd = r; wb_regwrite = 1'b1;
    id_branch = 1'b1; id_rs[AW-1:0] = r; id_rs_used = 2'b01;
  endtask

  typedef struct {
    logic [4:0] exr; logic exw; logic exl;
    logic [4:0] mr;  logic mw;  logic ml;
    logic [4:0] rs;  logic [1:0] used; logic br; int need;
  } vec_t;

  vec_t tv [9];
  logic [2:0] exp_q [$];
  logic [2:0] t4_pat [6];
  logic [2:0] got;

  initial begin
    tv[0] = '{5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 2'b01, 1'b1, 1};
    tv[1] = '{5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 2'b01, 1'b0, 0};
    tv[2] = '{5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b11, 1'b0, 0};
    tv[3] = '{5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 2'b00, 1'b1, 0};
    tv[4] = '{5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd6, 2'b10, 1'b1, 1};
    tv[5] = '{5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd6, 2'b10, 1'b0, 0};
    tv[6] = '{5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 2'b01, 1'b0, 0};
    tv[7] = '{5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 2'b10, 1'b1, 2};
    tv[8] = '{5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 2'b01, 1'b1, 1};
    // {stall_pc, bubble_idex, freeze_all} for the memory-wait scenario
    t4_pat = '{3'b110, 3'b101, 3'b101, 3'b101, 3'b110, 3'b000};

    idle(); s3_idle();
    #2;
    dmem_stall = 1'b1;
    #1;
    chk("rst_freeze", 32'(freeze_all), 32'd0);
    chk("rst_stall_pc", 32'(stall_pc), 32'd0);
    chk("rst_cnt_stall", 32'(cnt_stall), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    dmem_stall = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;

    // newest producer wins; x0 never forwarded
    cyc(); idle();
    mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
    ex_rs = {5'd0, 5'd5};
    #1;
    chk("t1_newest", 32'(ex_fwd_sel[1:0]), 32'h2);
    chk("t1_src2_x0", 32'(ex_fwd_sel[3:2]), 32'h0);
    cyc(); idle();
    mem_rd = 5'd0; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
    ex_rs = {5'd0, 5'd5};
    #1;
    chk("t1_wb", 32'(ex_fwd_sel[1:0]), 32'h1);
    chk("t1_mem_x0", 32'(ex_fwd_sel[3:2]), 32'h0);

    // load-use, one bubble
    clr();
    idle(); ex_rd = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    #1;
    chk("t2_bubble", 32'(bubble_idex), 32'd1);
    chk("t2_stall_ifid", 32'(stall_ifid), 32'd1);
    cyc(); idle(); mem_rd = 5'd7; mem_regwrite = 1'b1; mem_memread = 1'b1;
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    #1;
    chk("t2_released", 32'(stall_pc), 32'd0);
    chk("t2_cnt_loaduse", 32'(cnt_loaduse), 32'd1);
    chk("t2_cnt_stall", 32'(cnt_stall), 32'd1);

    // load feeding a branch, two bubbles
    clr();
    set_a(5'd8); #1;
    chk("t3_bub1", 32'(bubble_idex), 32'd1);
    cyc(); set_b(5'd8); #1;
    chk("t3_bub2", 32'(bubble_idex), 32'd1);
    cyc(); set_c(5'd8); #1;
    chk("t3_released", 32'(stall_pc), 32'd0);
    chk("t3_id_fwd_wb", 32'(id_fwd_sel[1:0]), 32'h1);
    chk("t3_cnt_stall", 32'(cnt_stall), 32'd2);

    // memory wait during the bubble sequence
    clr();
    for (int c = 0; c < 6; c++) exp_q.push_back(t4_pat[c]);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc();
      if (c == 0) set_a(5'd8);
      else if (c < 4) begin set_b(5'd8); dmem_stall = 1'b1; end
      else if (c == 4) set_b(5'd8);
      else set_c(5'd8);
      #1;
      got = {stall_pc, bubble_idex, freeze_all};
      chk($sformatf("t4_cycle%0d", c), 32'(got), 32'(exp_q.pop_front()));
    end
    chk("t4_cnt_stall", 32'(cnt_stall), 32'd5);

    // reset in the middle of a bubble sequence
    cyc(); set_a(5'd8);
    cyc(); set_b(5'd8); #1;
    chk("t5_pre", 32'(bubble_idex), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_bubble_rst", 32'(bubble_idex), 32'd0);
    chk("t5_stall_rst", 32'(stall_pc), 32'd0);
    chk("t5_cnt_rst", 32'(cnt_stall), 32'd0);
    cyc(); idle(); rst_n = 1'b1;
    #1;
    chk("t5_state_idle", 32'(dbg_state), 32'd0);

    // directed hazard table
    for (int v = 0; v < 9; v++) begin
      cyc(); idle();
      ex_rd = tv[v].exr; ex_regwrite = tv[v].exw; ex_memread = tv[v].exl;
      mem_rd = tv[v].mr; mem_regwrite = tv[v].mw; mem_memread = tv[v].ml;
      id_rs = {tv[v].rs, tv[v].rs}; id_rs_used = tv[v].used; id_branch = tv[v].br;
      #1;
      chk($sformatf("tv%0d_first", v), 32'(bubble_idex), 32'(tv[v].need > 0));
      cyc(); idle(); #1;
      chk($sformatf("tv%0d_second", v), 32'(bubble_idex), 32'(tv[v].need > 1));
      cyc();
    end

    // three sources, 2-bit counters saturate
    cyc(); s3_idle();
    s3_mem_rd = 5'd9; s3_mem_regwrite = 1'b1; s3_ex_rs = {5'd9, 10'd0};
    #1;
    chk("t6_src3_fwd", 32'(s3_ex_fwd_sel[5:4]), 32'h2);
    for (int e = 0; e < 5; e++) begin
      cyc(); s3_idle();
      s3_ex_rd = 5'd9; s3_ex_regwrite = 1'b1; s3_ex_memread = 1'b1;
      s3_id_rs = {5'd9, 10'd0}; s3_id_rs_used = 3'b100;
      #1;
      chk($sformatf("t6_bubble%0d", e), 32'(s3_bubble_idex), 32'd1);
      cyc(); s3_idle();
      #1;
      if (e == 1) chk("t6_cnt_two", 32'(s3_cnt_loaduse), 32'd2);
    end
    chk("t6_lu_sat", 32'(s3_cnt_loaduse), 32'd3);
    chk("t6_stall_sat", 32'(s3_cnt_stall), 32'd3);
    cyc(); s3_cnt_clr = 1'b1;
    cyc(); s3_cnt_clr = 1'b0;
    #1;
    chk("t6_clr", 32'(s3_cnt_loaduse), 32'd0);
    chk("t6_clr_stall", 32'(s3_cnt_stall), 32'd0);

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
